instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Dual-issue fetch stage directly downstream of program_counter. Takes the PC pair (pc_1, pc_2, ce),
//  issues a paired read to instruction memory (fixed 1-cycle read latency) and buffers the returned
//  instruction pairs with their PCs in a small FIFO. Presents one pair per cycle to decode with
//  valid/ready, back-pressures the PC via stall, and drops all buffered/in-flight work on flush.
// PARAMETERS
//  PC_WIDTH     32  PC/address width (value of `PC_WIDTH)
//  INSTR_WIDTH  32  instruction word width
//  DEPTH        4   FIFO entries (one entry = two instructions + two PCs); power of two, >=2
// PORTS
//  fq_i_clk         in   1            clock, all state on posedge
//  fq_i_rst         in   1            asynchronous reset, active-low
//  fq_i_ce          in   1            PC pair valid (from pc_o_ce)
//  fq_i_pc_1        in   PC_WIDTH     PC of older slot
//  fq_i_pc_2        in   PC_WIDTH     PC of younger slot
//  fq_o_stall       out  1            PC must hold its current pair
//  fq_o_imem_req    out  1            memory read strobe
//  fq_o_imem_addr_1 out  PC_WIDTH     read address slot 1
//  fq_o_imem_addr_2 out  PC_WIDTH     read address slot 2
//  fq_i_imem_data_1 in   INSTR_WIDTH  read data slot 1, valid cycle after req
//  fq_i_imem_data_2 in   INSTR_WIDTH  read data slot 2, valid cycle after req
//  fq_i_flush       in   1            redirect (change_pc): discard everything
//  fq_o_valid       out  1            head pair valid to decode
//  fq_i_ready       in   1            decode accepts head pair
//  fq_o_instr_1/2   out  INSTR_WIDTH  head instructions
//  fq_o_pc_1/2      out  PC_WIDTH     head PCs
// BEHAVIOUR
//  Reset (fq_i_rst=0, async): count=0, rd/wr ptr=0, pending=0; fq_o_valid=0, fq_o_stall=0,
//   fq_o_imem_req=0; instr/pc outputs 0; FIFO storage need not be cleared.
//  Request: fq_o_imem_req = fq_i_ce & ~fq_o_stall & ~fq_i_flush; addr_1/2 = pc_1/2 combinationally.
//  Pending: registered; set at edge when req=1, else cleared. Latched pc_1/2 kept alongside.
//  Capture: in cycle with pending=1 & ~flush, {imem_data, latched PCs} written at wr_ptr at edge.
//  Latency: ce in cycle N -> req N -> data N+1 -> fq_o_valid N+2 (no bypass path).
//  Head: fq_o_valid = (count!=0); outputs driven from storage[rd_ptr]; pop when valid & ready.
//  Stall (combinational, conservative): fq_o_stall = (count + pending) >= DEPTH; frees on next
//   cycle after a pop, never accounting for same-cycle pop.
//  Simultaneous push+pop: count unchanged, both pointers advance. Pointers wrap mod DEPTH.
//  Overflow impossible by stall; push when full = assertion failure in bench.
//  Flush (sync, dominates): at edge count=0, ptrs=0, pending=0; capture suppressed; no req issued
//   that cycle; fq_o_valid=0 from next cycle. Pop in flush cycle is irrelevant (queue emptied).
//  Reset mid-operation: identical to power-up reset; in-flight memory data ignored.
//  Count width clog2(DEPTH)+1; counting is pairwise, slots never split.
// STRUCTURE
//  Shared package/header: `PC_WIDTH, `INSTR_WIDTH, `FQ_DEPTH defaults, fetch-entry field offsets.
//  One sub-module: fetch_fifo (generic sync FIFO, async active-low reset, push/pop/flush,
//   count/full/empty). Top holds pending register, request/stall logic, capture muxing.
// TESTING (imem model: data = pc ^ 32'hA5A5_0000, 1-cycle latency)
//  1 Reset: hold rst=0 2 cycles, ce=1 -> valid=0, stall=0, req=0; outputs 0 throughout.
//  2 Stream: ready=1, PC pairs 0/4, 8/12 on consecutive cycles -> valid at N+2 with pc 0/4,
//    instr A5A5_0000/A5A5_0004, then 8/12 next cycle; stall never asserted.
//  3 Back-pressure: ready=0, ce=1 constant -> stall asserts once count+pending=4; exactly 4 pairs
//    stored, PC held; ready=1 -> pairs drain in order 0/4,8/12,16/20,24/28, stall drops.
//  4 Flush with pending=1 and count=2 -> next cycle valid=0, count=0; late data discarded;
//    new pair 0x100/0x104 after flush appears 2 cycles later as first head.
//  5 Full push+pop: count=3, pending=1, ready=1 -> count stays 3 across edge, order preserved.
//  6 Async reset pulse mid-stream (between edges) -> outputs zero immediately; recovery as test 2.

Source files
------------

// File: rtl/instr_fetch_queue_pkg.sv
// rtl/instr_fetch_queue_pkg.sv - shared widths, depth and fetch-entry field layout
package instr_fetch_queue_pkg;

    localparam int DEF_PC_WIDTH    = 32;
    localparam int DEF_INSTR_WIDTH = 32;
    localparam int FQ_DEPTH        = 4;

    // Entry layout, LSB first: pc_2, pc_1, instr_2, instr_1
    function automatic int entry_width(input int pw, input int iw);
        return 2 * pw + 2 * iw;
    endfunction

    function automatic int off_pc_2(input int pw);
        return 0 * pw;
    endfunction

    function automatic int off_pc_1(input int pw);
        return pw;
    endfunction

    function automatic int off_instr_2(input int pw);
        return 2 * pw;
    endfunction

    function automatic int off_instr_1(input int pw, input int iw);
        return 2 * pw + iw;
    endfunction

endpackage

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// rtl/instr_fetch_queue_fetch_fifo.sv - generic sync FIFO with flush and occupancy count
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; the head is only observed while count is non-zero
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - dual-issue fetch stage: paired imem request, pending tracking, fetch FIFO
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int DEPTH       = FQ_DEPTH
) (
    input  logic                   fq_i_clk,
    input  logic                   fq_i_rst,
    input  logic                   fq_i_ce,
    input  logic [PC_WIDTH-1:0]    fq_i_pc_1,
    input  logic [PC_WIDTH-1:0]    fq_i_pc_2,
    output logic                   fq_o_stall,
    output logic                   fq_o_imem_req,
    output logic [PC_WIDTH-1:0]    fq_o_imem_addr_1,
    output logic [PC_WIDTH-1:0]    fq_o_imem_addr_2,
    input  logic [INSTR_WIDTH-1:0] fq_i_imem_data_1,
    input  logic [INSTR_WIDTH-1:0] fq_i_imem_data_2,
    input  logic                   fq_i_flush,
    output logic                   fq_o_valid,
    input  logic                   fq_i_ready,
    output logic [INSTR_WIDTH-1:0] fq_o_instr_1,
    output logic [INSTR_WIDTH-1:0] fq_o_instr_2,
    output logic [PC_WIDTH-1:0]    fq_o_pc_1,
    output logic [PC_WIDTH-1:0]    fq_o_pc_2
);
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int EW     = entry_width(PC_WIDTH, INSTR_WIDTH);
    localparam int OFF_P2 = off_pc_2(PC_WIDTH);
    localparam int OFF_P1 = off_pc_1(PC_WIDTH);
    localparam int OFF_I2 = off_instr_2(PC_WIDTH);
    localparam int OFF_I1 = off_instr_1(PC_WIDTH, INSTR_WIDTH);

    logic                pending_q, pending_d;
    logic [PC_WIDTH-1:0] lat_pc_1_q, lat_pc_1_d;
    logic [PC_WIDTH-1:0] lat_pc_2_q, lat_pc_2_d;
    logic [CW-1:0]       fifo_count;
    logic                fifo_full, fifo_empty;
    logic                fifo_push, fifo_pop;
    logic [EW-1:0]       fifo_wdata, fifo_rdata;
    logic [CW:0]         occupancy;

    // Stall counts the in-flight pair as occupied and ignores a same-cycle pop
    always_comb begin
        occupancy     = {1'b0, fifo_count} + {{CW{1'b0}}, pending_q};
        fq_o_stall    = fifo_full | (occupancy >= (CW + 1)'(DEPTH));
        fq_o_imem_req = fq_i_rst & fq_i_ce & ~fq_o_stall & ~fq_i_flush;
    end

    assign fq_o_imem_addr_1 = fq_i_pc_1;
    assign fq_o_imem_addr_2 = fq_i_pc_2;

    always_comb begin
        pending_d  = fq_o_imem_req;
        lat_pc_1_d = fq_o_imem_req ? fq_i_pc_1 : lat_pc_1_q;
        lat_pc_2_d = fq_o_imem_req ? fq_i_pc_2 : lat_pc_2_q;
    end

    always_ff @(posedge fq_i_clk or negedge fq_i_rst) begin
        if (!fq_i_rst) begin
            pending_q  <= 1'b0;
            lat_pc_1_q <= '0;
            lat_pc_2_q <= '0;
        end else begin
            pending_q  <= pending_d;
            lat_pc_1_q <= lat_pc_1_d;
            lat_pc_2_q <= lat_pc_2_d;
        end
    end

    assign fifo_push  = pending_q & ~fq_i_flush;
    assign fifo_pop   = fq_o_valid & fq_i_ready;
    assign fifo_wdata = {fq_i_imem_data_1, fq_i_imem_data_2, lat_pc_1_q, lat_pc_2_q};

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (fq_i_clk),
        .rst_n (fq_i_rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fq_i_flush),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Head fields read as zero whenever nothing valid is presented
    always_comb begin
        fq_o_valid   = ~fifo_empty;
        fq_o_instr_1 = fq_o_valid ? fifo_rdata[OFF_I1 +: INSTR_WIDTH] : '0;
        fq_o_instr_2 = fq_o_valid ? fifo_rdata[OFF_I2 +: INSTR_WIDTH] : '0;
        fq_o_pc_1    = fq_o_valid ? fifo_rdata[OFF_P1 +: PC_WIDTH]    : '0;
        fq_o_pc_2    = fq_o_valid ? fifo_rdata[OFF_P2 +: PC_WIDTH]    : '0;
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - scoreboard bench for instr_fetch_queue
module tb_instr_fetch_queue;

    localparam logic [31:0] K     = 32'hA5A5_0000;
    localparam int          DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc1;
        logic [31:0] pc2;
        logic [31:0] i1;
        logic [31:0] i2;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0;
    logic [31:0] pc1 = '0;
    logic [31:0] pc2 = '0;
    logic        flush = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] d1, d2;
    logic        stall, req, valid;
    logic [31:0] a1, a2, i1o, i2o, p1o, p2o;

    int   vectors = 0;
    int   miscompares = 0;
    ent_t sb[$];
    logic pop_v;
    ent_t pop_exp, pop_got;

    instr_fetch_queue dut (
        .fq_i_clk         (clk),
        .fq_i_rst         (rst_n),
        .fq_i_ce          (ce),
        .fq_i_pc_1        (pc1),
        .fq_i_pc_2        (pc2),
        .fq_o_stall       (stall),
        .fq_o_imem_req    (req),
        .fq_o_imem_addr_1 (a1),
        .fq_o_imem_addr_2 (a2),
        .fq_i_imem_data_1 (d1),
        .fq_i_imem_data_2 (d2),
        .fq_i_flush       (flush),
        .fq_o_valid       (valid),
        .fq_i_ready       (ready),
        .fq_o_instr_1     (i1o),
        .fq_o_instr_2     (i2o),
        .fq_o_pc_1        (p1o),
        .fq_o_pc_2        (p2o)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        d1 <= a1 ^ K;
        d2 <= a2 ^ K;
    end

    // Scoreboard bookkeeping at the sampling point: push on accepted PC pair, pop on handshake
    task automatic observe();
        pop_v = 1'b0;
        if (flush) begin
            sb.delete();
            return;
        end
        if (valid && ready) begin
            pop_v   = 1'b1;
            pop_got = '{p1o, p2o, i1o, i2o};
            pop_exp = (sb.size() != 0) ? sb.pop_front() : '1;
        end
        if (ce && !stall && rst_n) begin
            sb.push_back('{pc1, pc2, pc1 ^ K, pc2 ^ K});
            vectors++;
            if (sb.size() > DEPTH) begin
                miscompares++;
                $display("FAIL overflow: sb depth %0d exceeds %0d", sb.size(), DEPTH);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce = 1'b1; pc1 = 32'h10; pc2 = 32'h14; ready = 1'b1; flush = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if ({valid, stall, req} !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_ctrl: valid/stall/req=%b expected 000", {valid, stall, req});
            end
            vectors++;
            if ({i1o, i2o, p1o, p2o} !== 128'h0) begin
                miscompares++;
                $display("FAIL reset_data: got %h expected 0", {i1o, i2o, p1o, p2o});
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1; ce = 1'b0;
        sb.delete();
    endtask

    task automatic test_stream(input logic [31:0] base);
        ready = 1'b1; flush = 1'b0;
        for (int c = 0; c < 6; c++) begin
            ce  = (c < 2);
            pc1 = base + 32'(8 * c);
            pc2 = pc1 + 32'd4;
            @(negedge clk);
            observe();
            if (pop_v) begin
                vectors++;
                if (pop_got !== pop_exp) begin
                    miscompares++;
                    $display("FAIL stream_head: got %h expected %h", pop_got, pop_exp);
                end
            end
            vectors++;
            if (stall !== 1'b0) begin
                miscompares++;
                $display("FAIL stream_stall c%0d: got %b expected 0", c, stall);
            end
            vectors++;
            if (valid !== (c == 2 || c == 3)) begin
                miscompares++;
                $display("FAIL stream_latency c%0d: valid %b expected %b", c, valid, (c == 2 || c == 3));
            end
            if (c == 2) begin
                vectors++;
                if ({p1o, p2o, i1o, i2o} !== {base, base + 32'd4, base ^ K, (base + 32'd4) ^ K}) begin
                    miscompares++;
                    $display("FAIL stream_first: got %h/%h %h/%h expected pc %h", p1o, p2o, i1o, i2o, base);
                end
            end
            if (c == 3) begin
                vectors++;
                if ({p1o, p2o} !== {base + 32'd8, base + 32'd12}) begin
                    miscompares++;
                    $display("FAIL stream_second: got %h/%h expected %h/%h", p1o, p2o, base + 32'd8, base + 32'd12);
                end
            end
            @(posedge clk); #1;
        end
        ce = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] p;
        p = 32'h0;
        ready = 1'b0; flush = 1'b0;
        for (int c = 0; c < 8; c++) begin
            ce = 1'b1; pc1 = p; pc2 = p + 32'd4;
            @(negedge clk);
            observe();
            vectors++;
            if (stall !== (c >= 4)) begin
                miscompares++;
                $display("FAIL bp_stall c%0d: got %b expected %b", c, stall, (c >= 4));
            end
            vectors++;
            if (req !== (c < 4)) begin
                miscompares++;
                $display("FAIL bp_req c%0d: got %b expected %b", c, req, (c < 4));
            end
            if (c < 4) p = p + 32'd8;
            @(posedge clk); #1;
        end
        ce = 1'b0; ready = 1'b1;
        for (int d = 0; d < 5; d++) begin
            @(negedge clk);
            observe();
            if (pop_v) begin
                vectors++;
                if (pop_got !== pop_exp) begin
                    miscompares++;
                    $display("FAIL bp_head: got %h expected %h", pop_got, pop_exp);
                end
            end
            vectors++;
            if (valid !== (d < 4)) begin
                miscompares++;
                $display("FAIL bp_drain_valid d%0d: got %b expected %b", d, valid, (d < 4));
            end
            if (d < 4) begin
                vectors++;
                if (p1o !== 32'(8 * d)) begin
                    miscompares++;
                    $display("FAIL bp_order d%0d: pc %h expected %h", d, p1o, 32'(8 * d));
                end
            end
            vectors++;
            if (stall !== (d == 0)) begin
                miscompares++;
                $display("FAIL bp_release d%0d: stall %b expected %b", d, stall, (d == 0));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            flush = (c == 3);
            ce    = (c <= 4);
            ready = (c >= 4);
            pc1   = (c == 4) ? 32'h100 : 32'h40 + 32'(8 * c);
            pc2   = pc1 + 32'd4;
            @(negedge clk);
            observe();
            if (pop_v) begin
                vectors++;
                if (pop_got !== pop_exp) begin
                    miscompares++;
                    $display("FAIL flush_head: got %h expected %h", pop_got, pop_exp);
                end
            end
            if (c == 3) begin
                vectors++;
                if ({valid, req} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL flush_cycle: valid/req %b expected 10", {valid, req});
                end
            end
            if (c == 4 || c == 5) begin
                vectors++;
                if ({valid, stall} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL flush_empty c%0d: valid/stall %b expected 00", c, {valid, stall});
                end
            end
            if (c == 6) begin
                vectors++;
                if ({valid, p1o, i1o} !== {1'b1, 32'h100, 32'h100 ^ K}) begin
                    miscompares++;
                    $display("FAIL flush_new_head: valid %b pc %h instr %h expected pc 100", valid, p1o, i1o);
                end
            end
            @(posedge clk); #1;
        end
        flush = 1'b0; ce = 1'b0;
    endtask

    task automatic test_push_pop();
        for (int c = 0; c < 9; c++) begin
            ce    = (c < 4);
            ready = (c >= 4);
            pc1   = 32'h300 + 32'(8 * c);
            pc2   = pc1 + 32'd4;
            @(negedge clk);
            observe();
            if (pop_v) begin
                vectors++;
                if (pop_got !== pop_exp) begin
                    miscompares++;
                    $display("FAIL pp_head: got %h expected %h", pop_got, pop_exp);
                end
            end
            if (c == 4 || c == 5) begin
                vectors++;
                if (stall !== (c == 4)) begin
                    miscompares++;
                    $display("FAIL pp_stall c%0d: got %b expected %b", c, stall, (c == 4));
                end
            end
            if (c >= 4) begin
                vectors++;
                if (valid !== (c < 8)) begin
                    miscompares++;
                    $display("FAIL pp_valid c%0d: got %b expected %b", c, valid, (c < 8));
                end
            end
            if (c == 7) begin
                vectors++;
                if (p1o !== 32'h318) begin
                    miscompares++;
                    $display("FAIL pp_last: pc %h expected 318", p1o);
                end
            end
            @(posedge clk); #1;
        end
        ready = 1'b0;
    endtask

    task automatic test_async_reset();
        ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            ce  = 1'b1;
            pc1 = 32'h400 + 32'(8 * c);
            pc2 = pc1 + 32'd4;
            @(negedge clk);
            observe();
            if (pop_v) begin
                vectors++;
                if (pop_got !== pop_exp) begin
                    miscompares++;
                    $display("FAIL ar_head: got %h expected %h", pop_got, pop_exp);
                end
            end
            @(posedge clk); #1;
        end
        ce = 1'b0;
        vectors++;
        if (valid !== 1'b1) begin
            miscompares++;
            $display("FAIL ar_pre: valid %b expected 1", valid);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({valid, stall, req, i1o, i2o, p1o, p2o} !== 131'h0) begin
            miscompares++;
            $display("FAIL ar_immediate: valid %b stall %b req %b pc %h expected all zero", valid, stall, req, p1o);
        end
        sb.delete();
        #1 rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ar_inflight: valid %b expected 0", valid);
        end
        @(posedge clk); #1;
        test_stream(32'h0);
    endtask

    initial begin
        test_reset();
        test_stream(32'h0);
        test_backpressure();
        test_flush();
        test_push_pop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
